// File: rtl/sw_arb_pkg.sv
// Shared types and helpers for the packet-aware weighted round-robin arbiter.
package sw_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

  localparam int unsigned WGT_MAX_W = 16;

  // Index width for n requesters, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A zero weight still earns one packet per turn.
  function automatic logic [WGT_MAX_W-1:0] eff_weight(input logic [WGT_MAX_W-1:0] w);
    return (w == '0) ? WGT_MAX_W'(1) : w;
  endfunction

endpackage

// File: rtl/rr_find_first.sv
// Circular find-first-set: first asserted request at or after start, wrapping.
module rr_find_first #(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned IW     = 2
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [IW-1:0]     start,
  output logic [IW-1:0]     idx,
  output logic              found
);

  logic [IW:0]   sum;
  logic [IW-1:0] pos;

  // Scan from the farthest offset down so the nearest hit is written last.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    sum   = '0;
    pos   = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      sum = {1'b0, start} + (IW+1)'(i);
      if (sum >= (IW+1)'(NUM_IN)) begin
        sum = sum - (IW+1)'(NUM_IN);
      end
      pos = sum[IW-1:0];
      if (req[pos]) begin
        idx   = pos;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcp_pkt_wrr_arb.sv
// Packet-locked weighted round-robin arbiter sharing one Decoupled output
// between NUM_IN input buffers; each input gets EW(i) packets per turn.
module dcp_pkt_wrr_arb
  import sw_arb_pkg::*;
#(
  parameter  int unsigned NUM_IN = 4,
  parameter  int unsigned DW     = 18,
  parameter  int unsigned WW     = 4,
  localparam int unsigned IW     = idx_width(NUM_IN)
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic [NUM_IN-1:0]         iReqVld,
  output logic [NUM_IN-1:0]         oReqRdy,
  input  logic [NUM_IN-1:0][DW-1:0] iReqPld,
  input  logic [NUM_IN-1:0]         iReqLast,
  input  logic [NUM_IN-1:0][WW-1:0] iWeight,
  output logic                      oOutVld,
  input  logic                      iOutRdy,
  output logic [DW-1:0]             oOutPld,
  output logic                      oOutLast,
  output logic [IW-1:0]             oGntIdx,
  output logic                      oBusy
);

  arb_state_e    state_q;
  logic [IW-1:0] ptr_q;
  logic [WW-1:0] cnt_q;
  logic [IW-1:0] gnt_q;

  logic [IW-1:0] win;
  logic          win_found;
  logic          beat;

  rr_find_first #(
    .NUM_IN (NUM_IN),
    .IW     (IW)
  ) u_find (
    .req   (iReqVld),
    .start (ptr_q),
    .idx   (win),
    .found (win_found)
  );

  // Zero-latency data path while a packet is locked; quiet otherwise.
  always_comb begin
    oOutVld  = 1'b0;
    oOutPld  = '0;
    oOutLast = 1'b0;
    oReqRdy  = '0;
    if (state_q == XFER) begin
      oOutVld        = iReqVld[gnt_q];
      oOutPld        = iReqPld[gnt_q];
      oOutLast       = iReqLast[gnt_q];
      oReqRdy[gnt_q] = iOutRdy;
    end
  end

  assign beat    = oOutVld && iOutRdy;
  assign oGntIdx = gnt_q;
  assign oBusy   = (state_q == XFER);

  // Grant FSM with per-input packet credit.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            if ((win != ptr_q) || (cnt_q == '0)) begin
              ptr_q <= win;
              cnt_q <= WW'(eff_weight(WGT_MAX_W'(iWeight[win])));
            end
            gnt_q   <= win;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (beat && oOutLast) begin
            state_q <= IDLE;
            if ((cnt_q == '0) || (cnt_q == WW'(1))) begin
              ptr_q <= (ptr_q == IW'(NUM_IN - 1)) ? '0 : ptr_q + IW'(1);
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q - WW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcp_pkt_wrr_arb.sv
// Directed self-checking bench for dcp_pkt_wrr_arb (NUM_IN=4, DW=18, WW=4).
module tb_dcp_pkt_wrr_arb;

  localparam int unsigned NUM_IN = 4;
  localparam int unsigned DW     = 18;
  localparam int unsigned WW     = 4;
  localparam int unsigned IW     = 2;

  logic                      iClk = 1'b0;
  logic                      iRst;
  logic [NUM_IN-1:0]         iReqVld;
  logic [NUM_IN-1:0]         oReqRdy;
  logic [NUM_IN-1:0][DW-1:0] iReqPld;
  logic [NUM_IN-1:0]         iReqLast;
  logic [NUM_IN-1:0][WW-1:0] iWeight;
  logic                      oOutVld;
  logic                      iOutRdy;
  logic [DW-1:0]             oOutPld;
  logic                      oOutLast;
  logic [IW-1:0]             oGntIdx;
  logic                      oBusy;

  int n_chk = 0;
  int n_err = 0;

  dcp_pkt_wrr_arb #(
    .NUM_IN (NUM_IN),
    .DW     (DW),
    .WW     (WW)
  ) dut (
    .iClk     (iClk),
    .iRst     (iRst),
    .iReqVld  (iReqVld),
    .oReqRdy  (oReqRdy),
    .iReqPld  (iReqPld),
    .iReqLast (iReqLast),
    .iWeight  (iWeight),
    .oOutVld  (oOutVld),
    .iOutRdy  (iOutRdy),
    .oOutPld  (oOutPld),
    .oOutLast (oOutLast),
    .oGntIdx  (oGntIdx),
    .oBusy    (oBusy)
  );

  always #5 iClk = ~iClk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic do_reset();
    iRst     = 1'b1;
    iReqVld  = '0;
    iReqLast = '0;
    iOutRdy  = 1'b1;
    iWeight  = {4'd1, 4'd1, 4'd1, 4'd1};
    for (int i = 0; i < NUM_IN; i++) iReqPld[i] = DW'(16 * i + 1);
    tick();
    iRst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_seq[8];
    int beats;
    logic rdy;
    exp_seq = '{0, 0, 1, 2, 3, 0, 0, 1};

    // Reset state.
    do_reset();
    iRst = 1'b1;
    #1;
    chk("rst_busy", 32'(oBusy), 0);
    chk("rst_vld", 32'(oOutVld), 0);
    chk("rst_rdy", 32'(oReqRdy), 0);
    chk("rst_gnt", 32'(oGntIdx), 0);
    chk("rst_pld", 32'(oOutPld), 0);
    chk("rst_last", 32'(oOutLast), 0);
    iRst = 1'b0;

    // Weighted order with weights {2,1,1,1} and single-beat packets.
    do_reset();
    iWeight  = {4'd1, 4'd1, 4'd1, 4'd2};
    iReqVld  = 4'hF;
    iReqLast = 4'hF;
    for (int p = 0; p < 8; p++) begin
      #1;
      chk("wo_idle_vld", 32'(oOutVld), 0);
      chk("wo_idle_busy", 32'(oBusy), 0);
      chk("wo_idle_rdy", 32'(oReqRdy), 0);
      tick();
      #1;
      chk("wo_gnt", 32'(oGntIdx), 32'(exp_seq[p]));
      chk("wo_vld", 32'(oOutVld), 1);
      chk("wo_pld", 32'(oOutPld), 32'(16 * exp_seq[p] + 1));
      chk("wo_rdy", 32'(oReqRdy), 32'(1 << exp_seq[p]));
      tick();
    end

    // Packet lock: input 1 holds the port for 5 beats while input 0 waits.
    do_reset();
    iReqVld = 4'b0010;
    tick();
    iReqVld = 4'b0011;
    for (int b = 1; b <= 5; b++) begin
      iReqPld[1] = DW'(100 + b);
      iReqLast   = (b == 5) ? 4'b0010 : 4'b0000;
      #1;
      chk("lk_gnt", 32'(oGntIdx), 1);
      chk("lk_vld", 32'(oOutVld), 1);
      chk("lk_pld", 32'(oOutPld), 32'(100 + b));
      chk("lk_rdy", 32'(oReqRdy), 32'h2);
      tick();
    end
    iReqVld  = 4'b0001;
    iReqLast = 4'hF;
    #1;
    chk("lk_idle_busy", 32'(oBusy), 0);
    tick();
    chk("lk_next_gnt", 32'(oGntIdx), 0);
    chk("lk_next_busy", 32'(oBusy), 1);

    // Sparse request: input 2 keeps its credit only while it still requests.
    do_reset();
    iWeight  = {4'd1, 4'd3, 4'd1, 4'd1};
    iReqVld  = 4'b0100;
    iReqLast = 4'hF;
    tick();
    chk("sp_gnt0", 32'(oGntIdx), 2);
    chk("sp_busy0", 32'(oBusy), 1);
    tick();
    iReqVld = 4'b0101;
    tick();
    chk("sp_gnt_keep", 32'(oGntIdx), 2);
    tick();
    iReqVld = 4'b0001;
    tick();
    chk("sp_gnt_move", 32'(oGntIdx), 0);
    chk("sp_pld_move", 32'(oOutPld), 1);

    // Zero weight on input 3 plus alternating backpressure on a 4-beat packet.
    do_reset();
    iWeight  = {4'd0, 4'd1, 4'd1, 4'd1};
    iReqVld  = 4'b1000;
    iReqLast = 4'b0000;
    tick();
    beats = 0;
    for (int c = 0; c < 7; c++) begin
      rdy        = ((c % 2) == 0);
      iOutRdy    = rdy;
      iReqPld[3] = DW'(200 + c / 2);
      iReqLast   = (c / 2 == 3) ? 4'b1000 : 4'b0000;
      #1;
      chk("bp_rdy", 32'(oReqRdy), rdy ? 32'h8 : 32'h0);
      chk("bp_vld", 32'(oOutVld), 1);
      chk("bp_pld", 32'(oOutPld), 32'(200 + c / 2));
      if (c == 6) chk("bp_last", 32'(oOutLast), 1);
      if (oOutVld && iOutRdy) beats++;
      tick();
    end
    chk("bp_beats", 32'(beats), 4);
    chk("bp_busy_end", 32'(oBusy), 0);
    iOutRdy  = 1'b1;
    iReqVld  = 4'b1001;
    iReqLast = 4'hF;
    tick();
    chk("bp_wrap_gnt", 32'(oGntIdx), 0);

    // Source stall mid-packet: grant held, no other ready raised.
    do_reset();
    iReqVld  = 4'hF;
    iReqLast = 4'h0;
    iReqPld[0] = DW'(300);
    tick();
    #1;
    chk("st_beat1", 32'(oOutPld), 300);
    tick();
    iReqVld = 4'b1110;
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("st_vld", 32'(oOutVld), 0);
      chk("st_rdy", 32'(oReqRdy), 32'h1);
      chk("st_gnt", 32'(oGntIdx), 0);
      chk("st_busy", 32'(oBusy), 1);
      tick();
    end
    iReqVld    = 4'hF;
    iReqLast   = 4'b0001;
    iReqPld[0] = DW'(301);
    #1;
    chk("st_resume_pld", 32'(oOutPld), 301);
    chk("st_resume_vld", 32'(oOutVld), 1);
    tick();
    chk("st_done_busy", 32'(oBusy), 0);

    // Reset on beat 2 of a 4-beat packet from input 2.
    do_reset();
    iReqVld  = 4'b0100;
    iReqLast = 4'h0;
    tick();
    tick();
    iRst = 1'b1;
    #1;
    chk("mr_busy", 32'(oBusy), 0);
    chk("mr_vld", 32'(oOutVld), 0);
    chk("mr_rdy", 32'(oReqRdy), 0);
    chk("mr_gnt", 32'(oGntIdx), 0);
    tick();
    iReqVld  = 4'b0110;
    iReqLast = 4'hF;
    iRst     = 1'b0;
    #1;
    chk("mr_idle_busy", 32'(oBusy), 0);
    tick();
    chk("mr_gnt_after", 32'(oGntIdx), 1);
    chk("mr_rdy_after", 32'(oReqRdy), 32'h2);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
